// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared codes for the EX-stage ALU control decoder and its RV32M multiply/divide engine.
// Optional build macro used by the engine: MULDIV_FAST_MUL_EN.
package alu_ctrl_muldiv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] OPC_OP    = 5'b01100;
    localparam logic [4:0] OPC_OPIMM = 5'b00100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // Base integer op for a funct3; alt selects the arithmetic right shift.
    function automatic logic [3:0] base_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        sel = ALU_PASS;
        case (f3)
            F3_ADD:  sel = ALU_ADD;
            F3_SLL:  sel = ALU_SLL;
            F3_SLT:  sel = ALU_SLT;
            F3_SLTU: sel = ALU_SLTU;
            F3_XOR:  sel = ALU_XOR;
            F3_SR:   sel = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   sel = ALU_OR;
            F3_AND:  sel = ALU_AND;
            default: sel = ALU_PASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/md_iter_engine.sv
// Iterative RV32M engine: shift-add multiply and restoring divide on operand magnitudes.
// MULDIV_FAST_MUL_EN replaces the multiply iterations with a single-cycle product.
module md_iter_engine
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_result,
    output logic            md_valid,
    output md_state_e       state_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]   a_q, a_d, res_q, res_d;
    logic [2*XLEN-1:0] p_q, p_d;

    logic              s1, s2, a_sgn, b_sgn;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] p_step, pf;
    logic [XLEN-1:0]   qf, rf, res_fin;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext1, ext2, prod_fast;
`endif

    // p_q holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        s1    = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
        s2    = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
        a_sgn = s1 & rs1[XLEN-1];
        b_sgn = s2 & rs2[XLEN-1];
        a_mag = a_sgn ? -rs1 : rs1;
        b_mag = b_sgn ? -rs2 : rs2;
`ifdef MULDIV_FAST_MUL_EN
        ext1      = s1 ? {{XLEN{rs1[XLEN-1]}}, rs1} : {{XLEN{1'b0}}, rs1};
        ext2      = s2 ? {{XLEN{rs2[XLEN-1]}}, rs2} : {{XLEN{1'b0}}, rs2};
        prod_fast = ext1 * ext2;
`endif

        mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        div_trial = p_q[2*XLEN-1:XLEN-1] - {1'b0, a_q};
        if (st_q == MD_MUL) begin
            p_step = {mul_sum, p_q[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            p_step = {div_trial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        end else begin
            p_step = {p_q[2*XLEN-2:0], 1'b0};
        end

        pf = neg_q ? -p_step : p_step;
        qf = neg_q ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
        rf = rneg_q ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
        if (st_q == MD_MUL) begin
            res_fin = (f3_q == F3_MUL) ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN];
        end else begin
            res_fin = f3_q[1] ? rf : qf;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        f3_d   = f3_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        a_d    = a_q;
        res_d  = res_q;
        p_d    = p_q;
        case (st_q)
            MD_IDLE: begin
                if (start) begin
                    f3_d   = funct3;
                    neg_d  = a_sgn ^ b_sgn;
                    rneg_d = a_sgn;
                    if (!funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        res_d = (funct3 == F3_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
                        st_d  = MD_DONE;
`else
                        a_d   = a_mag;
                        p_d   = {{XLEN{1'b0}}, b_mag};
                        cnt_d = CNT_LOAD;
                        st_d  = MD_MUL;
`endif
                    end else if (rs2 == '0) begin
                        res_d = funct3[1] ? rs1 : '1;
                        st_d  = MD_DONE;
                    end else if (s1 && rs1 == INT_MIN && rs2 == '1) begin
                        res_d = funct3[1] ? '0 : rs1;
                        st_d  = MD_DONE;
                    end else begin
                        a_d   = b_mag;
                        p_d   = {{XLEN{1'b0}}, a_mag};
                        cnt_d = CNT_LOAD;
                        st_d  = MD_DIV;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                p_d   = p_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d = res_fin;
                    st_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (out_ready) st_d = MD_IDLE;
            end
            default: st_d = MD_IDLE;
        endcase
        if (flush) st_d = MD_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= MD_IDLE;
            cnt_q  <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            a_q    <= '0;
            res_q  <= '0;
            p_q    <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            f3_q   <= f3_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            a_q    <= a_d;
            res_q  <= res_d;
            p_q    <= p_d;
        end
    end

    assign md_result = res_q;
    assign md_valid  = (st_q == MD_DONE);
    assign state_o   = st_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with an attached iterative RV32M engine.
// Build option MULDIV_FAST_MUL_EN (single-cycle multiply) is handled inside md_iter_engine.
module alu_ctrl_muldiv
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUop,
    input  logic [4:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            in_valid,
    input  logic            flush,
    input  logic            out_ready,
    output logic [3:0]      ALUsel,
    output logic            is_muldiv,
    output logic            stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_valid
);

    md_state_e md_state;
    logic      md_start;

    always_comb begin
        ALUsel    = ALU_PASS;
        is_muldiv = 1'b0;
        case (ALUop)
            2'b00: ALUsel = ALU_ADD;
            2'b01: ALUsel = ALU_SUB;
            2'b11: ALUsel = ALU_PASS;
            default: begin
                if (opcode == OPC_OPIMM) begin
                    ALUsel = base_sel(funct3, funct7[5]);
                end else if (opcode == OPC_OP) begin
                    case (funct7)
                        F7_MULDIV: is_muldiv = 1'b1;
                        F7_BASE:   ALUsel = base_sel(funct3, 1'b0);
                        F7_ALT: begin
                            if (funct3 == F3_ADD)     ALUsel = ALU_SUB;
                            else if (funct3 == F3_SR) ALUsel = ALU_SRA;
                        end
                        default:   ALUsel = ALU_PASS;
                    endcase
                end
            end
        endcase
    end

    // Result handshake: the engine presents md_result with md_valid held high in DONE,
    // and the transfer completes on the rising edge where md_valid & out_ready are both high.
    assign md_start = in_valid & is_muldiv & ~flush;
    assign stall    = in_valid & is_muldiv & ~((md_state == MD_DONE) & out_ready);

    md_iter_engine #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_ready (out_ready),
        .md_result (md_result),
        .md_valid  (md_valid),
        .state_o   (md_state)
    );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv (XLEN = 32) against an arithmetic reference model.
module tb_alu_ctrl_muldiv;
  import alu_ctrl_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [3:0] BASE_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  logic            clk;
  logic            rst_n;
  logic [1:0]      ALUop;
  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1, rs2;
  logic            in_valid, flush, out_ready;
  logic [3:0]      ALUsel;
  logic            is_muldiv, stall, md_valid;
  logic [XLEN-1:0] md_result;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ctrl_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .in_valid(in_valid), .flush(flush),
    .out_ready(out_ready), .ALUsel(ALUsel), .is_muldiv(is_muldiv), .stall(stall),
    .md_result(md_result), .md_valid(md_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference models ----------------
  function automatic void ref_dec(input logic [1:0] op, input logic [4:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, output logic [3:0] sel, output logic md);
    md = 1'b0;
    sel = ALU_PASS;
    if (op == 2'b00) sel = ALU_ADD;
    else if (op == 2'b01) sel = ALU_SUB;
    else if (op == 2'b10) begin
      if (opc == 5'b00100) sel = (f3 == 3'd5 && f7[5]) ? ALU_SRA : BASE_TAB[f3];
      else if (opc == 5'b01100) begin
        if (f7 == 7'h01) md = 1'b1;
        else if (f7 == 7'h00) sel = BASE_TAB[f3];
        else if (f7 == 7'h20) sel = (f3 == 3'd0) ? ALU_SUB : (f3 == 3'd5) ? ALU_SRA : ALU_PASS;
      end
    end
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return a; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return 32'h0; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return XLEN + 1;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUop = 2'b10; opcode = 5'b01100; funct7 = 7'h01; funct3 = f3;
    rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_r;
    int exp_lat, lat;
    exp_r = ref_md(f3, a, b);
    exp_lat = ref_lat(f3, a, b);
    @(negedge clk);
    drive_md(f3, a, b);
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL accept_stall f3=%0d: got %b want 1", f3, stall); end
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin rs1 = $urandom; rs2 = $urandom; end
      if (md_valid === 1'b1) break;
    end
    tests_run++;
    if (lat != exp_lat) begin tests_failed++; $display("FAIL latency f3=%0d a=%h b=%h: got %0d want %0d", f3, a, b, lat, exp_lat); end
    tests_run++;
    if (md_result !== exp_r) begin tests_failed++; $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, md_result, exp_r); end
    repeat (hold) begin
      @(negedge clk);
      tests_run++;
      if (md_valid !== 1'b1 || md_result !== exp_r || stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL done_hold: got valid=%b res=%h stall=%b want valid=1 res=%h stall=1", md_valid, md_result, stall, exp_r);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL release_stall: got %b want 0", stall); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests_run++;
    if (md_valid !== 1'b0) begin tests_failed++; $display("FAIL after_handshake: got valid=%b want 0", md_valid); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ALUop = 2'b00; opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0;
    #12;
    tests_run++;
    if (md_valid !== 1'b0 || md_result !== 32'h0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got valid=%b res=%h stall=%b want 0 0 0", md_valid, md_result, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [3:0] exp_sel;
    logic exp_md;
    logic [4:0] opcs [3];
    logic [6:0] f7s [4];
    opcs = '{5'b01100, 5'b00100, 5'b00000};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    ALUop = 2'b10; opcode = 5'b01100; funct3 = 3'b000; funct7 = 7'h20;
    #1;
    tests_run++;
    if (ALUsel !== ALU_SUB || is_muldiv !== 1'b0 || stall !== 1'b0) begin
      tests_failed++; $display("FAIL dec_sub: got sel=%0d md=%b stall=%b want %0d 0 0", ALUsel, is_muldiv, stall, ALU_SUB);
    end
    opcode = 5'b00100; funct3 = 3'b101; funct7 = 7'h20;
    #1;
    tests_run++;
    if (ALUsel !== ALU_SRA) begin tests_failed++; $display("FAIL dec_srai: got %0d want %0d", ALUsel, ALU_SRA); end
    for (int i = 0; i < 60; i++) begin
      ALUop = 2'($urandom_range(0, 3));
      if (i < 40) ALUop = 2'b10;
      opcs[2] = 5'($urandom);
      f7s[3] = 7'($urandom);
      opcode = opcs[$urandom_range(0, 2)];
      funct7 = f7s[$urandom_range(0, 3)];
      funct3 = 3'($urandom);
      in_valid = 1'($urandom);
      #1;
      ref_dec(ALUop, opcode, funct3, funct7, exp_sel, exp_md);
      tests_run++;
      if (ALUsel !== exp_sel || is_muldiv !== exp_md || stall !== (exp_md & in_valid)) begin
        tests_failed++;
        $display("FAIL dec_rand op=%b opc=%b f3=%b f7=%b: got sel=%0d md=%b stall=%b want %0d %b %b",
                 ALUop, opcode, funct3, funct7, ALUsel, is_muldiv, stall, exp_sel, exp_md, exp_md & in_valid);
      end
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_mul();
    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    run_md(3'd3, 32'hFFFF_FFFE, 32'd3, 0);
    run_md(3'd2, 32'hFFFF_FFFE, 32'd3, 1);
  endtask

  task automatic test_div();
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_md(3'd5, 32'd100, 32'd7, 0);
    run_md(3'd7, 32'd100, 32'd7, 0);
  endtask

  task automatic test_special();
    run_md(3'd5, 32'd5, 32'd0, 0);
    run_md(3'd6, 32'd5, 32'd0, 0);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_handshake();
    run_md(3'd1, 32'h1234_5678, 32'h8765_4321, 5);
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    drive_md(3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (md_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_edge: got valid=%b want 0", md_valid); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (md_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL flush_discard: got valid rising=1 want 0"); end
    run_md(3'd0, 32'd7, 32'd6, 0);
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    drive_md(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (md_valid !== 1'b0 || md_result !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mid_div: got valid=%b res=%h want 0 0", md_valid, md_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    @(negedge clk);
    drive_md(3'd0, 32'd9, 32'd9);
    n = 0;
    while (n < 100 && md_valid !== 1'b1) begin @(posedge clk); n++; #1; end
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (md_valid !== 1'b0 || md_result !== 32'h0) begin
      tests_failed++; $display("FAIL reset_in_done: got valid=%b res=%h want 0 0", md_valid, md_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_md(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_random();
    logic [31:0] picks [5];
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      picks = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, $urandom};
      a = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      run_md(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_special();
    test_handshake();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
